// File: rtl/led_pattern_engine.sv
// Multi-mode LED animation engine: Johnson fill, bounce, binary count and PWM breathe.
// It supports run/pause and forward/reverse stepping from a prescaled step tick.
module led_pattern_engine #(
  parameter int unsigned WIDTH      = 5,
  parameter int unsigned DELAY_SIZE = 25,
  parameter int unsigned PWM_BITS   = 8,
  parameter bit          ACTIVE_LOW = 1'b1
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             reverse,
  input  logic             pause,
  input  logic             mode_next,
  output logic [1:0]       mode,
  output logic [WIDTH-1:0] led
);

  function automatic int unsigned max3(int unsigned a, int unsigned b, int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  localparam int unsigned SW          = max3($clog2(2 * WIDTH), WIDTH, PWM_BITS + 1);
  localparam int unsigned LOWB        = DELAY_SIZE - PWM_BITS;
  localparam int unsigned JOHN_MAX    = 2 * WIDTH - 1;
  localparam int unsigned BOUNCE_MAX  = 2 * WIDTH - 3;
  localparam int unsigned BIN_MAX     = (2 ** WIDTH) - 1;
  localparam int unsigned BREATHE_MAX = (2 ** (PWM_BITS + 1)) - 1;

  typedef enum logic [1:0] {
    M_JOHNSON = 2'd0,
    M_BOUNCE  = 2'd1,
    M_BINARY  = 2'd2,
    M_BREATHE = 2'd3
  } mode_e;

  mode_e                 mode_q, mode_d;
  logic [DELAY_SIZE-1:0] presc_q, presc_d;
  logic [SW-1:0]         step_q, step_d, step_max;
  logic [PWM_BITS-1:0]   pwm_q;
  logic [PWM_BITS-1:0]   duty;
  logic [WIDTH-1:0]      pattern;
  logic                  tick;
  int unsigned           s;
  int unsigned           p;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) mode_q <= M_JOHNSON;
    else       mode_q <= mode_d;
  end

  // Next mode, prescaler and step; a mode change restarts the animation and beats a tick.
  always_comb begin
    mode_d   = mode_q;
    presc_d  = presc_q;
    step_d   = step_q;
    step_max = SW'(JOHN_MAX);
    tick     = 1'b0;
    case (mode_q)
      M_JOHNSON: step_max = SW'(JOHN_MAX);
      M_BOUNCE:  step_max = SW'(BOUNCE_MAX);
      M_BINARY:  step_max = SW'(BIN_MAX);
      M_BREATHE: step_max = SW'(BREATHE_MAX);
      default:   step_max = SW'(JOHN_MAX);
    endcase
    if (!pause) begin
      presc_d = presc_q + DELAY_SIZE'(1);
      tick    = (mode_q == M_BREATHE) ? (&presc_q[LOWB-1:0]) : (&presc_q);
    end
    if (mode_next) begin
      mode_d  = mode_e'(2'(mode_q + 2'd1));
      step_d  = '0;
      presc_d = '0;
    end else if (tick) begin
      if (reverse) step_d = (step_q == '0) ? step_max : step_q - SW'(1);
      else         step_d = (step_q == step_max) ? '0 : step_q + SW'(1);
    end
  end

  // Pattern decode from the current step.
  always_comb begin
    pattern = '0;
    s       = 32'(step_q);
    p       = 0;
    duty    = '0;
    case (mode_q)
      M_JOHNSON: begin
        for (int unsigned i = 0; i < WIDTH; i++)
          pattern[i] = (s <= WIDTH) ? (i < s) : (i >= s - WIDTH);
      end
      M_BOUNCE: begin
        p = (s < WIDTH) ? s : (2 * WIDTH - 2 - s);
        for (int unsigned i = 0; i < WIDTH; i++)
          pattern[i] = (i == p);
      end
      M_BINARY: pattern = step_q[WIDTH-1:0];
      M_BREATHE: begin
        // Upper half of the step range mirrors the lower half: 2**(P+1)-1-s == ~s[P-1:0].
        duty    = step_q[PWM_BITS] ? ~step_q[PWM_BITS-1:0] : step_q[PWM_BITS-1:0];
        pattern = {WIDTH{pwm_q < duty}};
      end
      default: pattern = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      presc_q <= '0;
      step_q  <= '0;
      pwm_q   <= '0;
      led     <= {WIDTH{ACTIVE_LOW}};
    end else begin
      presc_q <= presc_d;
      step_q  <= step_d;
      pwm_q   <= pwm_q + PWM_BITS'(1);
      led     <= pattern ^ {WIDTH{ACTIVE_LOW}};
    end
  end

  assign mode = mode_q;

endmodule

// File: tb/tb_led_pattern_engine.sv
// Self-checking bench for led_pattern_engine: directed literal checks plus randomized run
// compared every cycle against a behavioural model.
module tb_led_pattern_engine;

  localparam int unsigned W  = 4;
  localparam int unsigned D  = 3;
  localparam int unsigned P  = 2;
  localparam bit          AL = 1'b1;

  logic       clk = 1'b0;
  logic       rstn;
  logic       reverse;
  logic       pause;
  logic       mode_next;
  logic [1:0] mode;
  logic [3:0] led;

  int vectors    = 0;
  int miscompares = 0;
  bit chk_en     = 1'b0;

  led_pattern_engine #(.WIDTH(W), .DELAY_SIZE(D), .PWM_BITS(P), .ACTIVE_LOW(AL)) dut (
    .clk(clk), .rstn(rstn), .reverse(reverse), .pause(pause),
    .mode_next(mode_next), .mode(mode), .led(led)
  );

  always #5 clk = ~clk;

  // Behavioural model
  int unsigned m_presc, m_step, m_mode, m_pwm;
  logic [3:0]  led_exp;
  logic [1:0]  mode_exp;

  function automatic int unsigned modulus(int unsigned md);
    case (md)
      0: return 2 * W;
      1: return 2 * W - 2;
      2: return 1 << W;
      default: return 1 << (P + 1);
    endcase
  endfunction

  function automatic logic [3:0] pat(int unsigned s, int unsigned md, int unsigned pw);
    int unsigned v, q, duty, all;
    all = (1 << W) - 1;
    case (md)
      0: v = (s <= W) ? ((1 << s) - 1) : (all << (s - W));
      1: begin q = (s < W) ? s : (2 * W - 2 - s); v = 1 << q; end
      2: v = s % (1 << W);
      default: begin
        duty = (s < (1 << P)) ? s : ((1 << (P + 1)) - 1 - s);
        v = (pw < duty) ? all : 0;
      end
    endcase
    return 4'(v & all);
  endfunction

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      m_presc = 0; m_step = 0; m_mode = 0; m_pwm = 0;
      led_exp = AL ? 4'hF : 4'h0;
      mode_exp = 2'd0;
    end else begin
      bit tk;
      int unsigned n;
      led_exp = pat(m_step, m_mode, m_pwm) ^ (AL ? 4'hF : 4'h0);
      tk = !pause && ((m_mode < 3) ? (m_presc % (1 << D) == (1 << D) - 1)
                                   : (m_presc % (1 << (D - P)) == (1 << (D - P)) - 1));
      n = modulus(m_mode);
      if (mode_next) begin
        m_mode = (m_mode + 1) % 4; m_step = 0; m_presc = 0;
      end else begin
        if (!pause) m_presc = (m_presc + 1) % (1 << D);
        if (tk) m_step = reverse ? (m_step + n - 1) % n : (m_step + 1) % n;
      end
      m_pwm = (m_pwm + 1) % (1 << P);
      mode_exp = 2'(m_mode);
    end
  end

  // Per-cycle compare against the model
  always @(negedge clk) begin
    if (chk_en) begin
      vectors++;
      if (led !== led_exp || mode !== mode_exp) begin
        miscompares++;
        $display("FAIL model t=%0t led/mode got %b/%0d expected %b/%0d",
                 $time, led, mode, led_exp, mode_exp);
      end
    end
  end

  task automatic check(input string name, input logic [3:0] got, input logic [3:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got %b expected %b", name, got, exp);
    end
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
  endtask

  logic [3:0] john_tab [9];

  initial begin
    john_tab = '{4'hF, 4'hE, 4'hC, 4'h8, 4'h0, 4'h1, 4'h3, 4'h7, 4'hF};
    rstn = 1'b1; reverse = 1'b0; pause = 1'b0; mode_next = 1'b0;
    #2 rstn = 1'b0;
    @(negedge clk);
    check("reset_led", led, 4'hF);
    check("reset_mode", 4'(mode), 4'h0);
    rstn = 1'b1;
    chk_en = 1'b1;

    // Johnson forward: new led value one clk after each 8-clk tick
    @(negedge clk);
    check("john_0", led, john_tab[0]);
    for (int k = 1; k < 9; k++) begin
      repeat (8) @(negedge clk);
      check($sformatf("john_%0d", k), led, john_tab[k]);
    end

    // Mode advance to bounce
    mode_next = 1'b1;
    @(negedge clk);
    mode_next = 1'b0;
    check("mode_adv", 4'(mode), 4'h1);
    @(negedge clk);
    check("bounce_0", led, 4'b1110);
    repeat (8) @(negedge clk);
    check("bounce_1", led, 4'b1101);

    // Async reset mid-run
    #3 rstn = 1'b0;
    #1;
    check("midrst_led", led, 4'hF);
    check("midrst_mode", 4'(mode), 4'h0);
    @(negedge clk);
    rstn = 1'b1;

    // Johnson reverse from step 0
    reverse = 1'b1;
    repeat (9) @(negedge clk);
    check("rev_first", led, 4'b0111);
    repeat (8) @(negedge clk);
    check("rev_second", led, 4'b0011);

    // Pause mid-step holds the led
    repeat (3) @(negedge clk);
    pause = 1'b1;
    repeat (20) @(negedge clk);
    check("pause_hold", led, 4'b0011);
    pause = 1'b0;
    reverse = 1'b0;

    // Randomized run
    for (int c = 0; c < 6000; c++) begin
      @(negedge clk);
      mode_next = ($urandom_range(0, 59) == 0);
      if ($urandom_range(0, 29) == 0) pause = ~pause;
      if ($urandom_range(0, 39) == 0) reverse = ~reverse;
      rstn = !($urandom_range(0, 1999) == 0);
    end
    @(negedge clk);
    rstn = 1'b1; mode_next = 1'b0;
    repeat (4) @(negedge clk);
    chk_en = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
